bus_grant_sched: RTL and testbench

Round-robin bus-ownership scheduler that drives the active-low three-state enables of the hex-buffer groups sharing a common data bus. It grants the bus to exactly one requester at a time and inserts a programmable dead (turnaround) gap between owners, so no two buffer groups ever drive the bus together. An optional hold timeout stops a stuck requester from starving the others. It sits beside the buffer packages and replaces ad-hoc decode of their G pins.

---
 rtl/bus_grant_sched.sv | 126 ++++++++++++
 tb/tb_bus_grant_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_sched.sv
// Round-robin bus-ownership scheduler driving the active-low hex-buffer group enables.
// Optional hold timeout is compiled in when BUS_GRANT_TIMEOUT_EN is defined.
module bus_grant_sched #(
  parameter int unsigned N       = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic         LOCK,
  output logic [N-1:0] _G,
  output logic [N-1:0] GNT,
  output logic         BUSY,
  output logic         TMO
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win, sel;
  logic [2:0]    gap_q, gap_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, tmo_q, tmo_d;
  logic          any_req, grant, forced;

  // First set request scanning from the priority pointer, wrapping at N.
  always_comb begin : arbiter
    win     = '0;
    sel     = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      sel = IW'((32'(ptr_q) + i) % N);
      if (!any_req && REQ[sel]) begin
        any_req = 1'b1;
        win     = sel;
      end
    end
  end

`ifdef BUS_GRANT_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAXHOLD);
  logic [HW-1:0] hold_q;
  logic          expired;

  // hold_q counts completed OWN cycles and saturates one short of MAXHOLD,
  // so expiry is seen on the edge that closes the MAXHOLD-th OWN cycle.
  assign expired = (hold_q == HW'(MAXHOLD - 1));
  always_ff @(posedge CLK) begin
    if (RST || grant) hold_q <= '0;
    else if (state_q == OWN && !expired) hold_q <= hold_q + 1'b1;
  end

  assign forced = expired && !LOCK && REQ[owner_q] && |(REQ & ~gnt_q);
`else
  assign forced = 1'b0;
`endif

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    grant   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: grant = any_req;
      OWN: begin
        if ((!REQ[owner_q] && !LOCK) || forced) begin
          tmo_d   = forced;
          state_d = IDLE;
          if (TURN > 0) begin
            state_d = GAP;
            gap_d   = 3'(TURN);
          end else begin
            grant = any_req;
          end
        end
      end
      GAP: begin
        if (gap_q <= 3'd1) begin
          state_d = IDLE;
          grant   = any_req;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = OWN;
      owner_d = win;
      ptr_d   = (32'(win) == N - 1) ? '0 : win + IW'(1);
    end
    gnt_d = '0;
    if (state_d == OWN) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      busy_q  <= (state_d == OWN);
      tmo_q   <= tmo_d;
    end
  end

  assign GNT  = gnt_q;
  assign _G   = ~gnt_q;
  assign BUSY = busy_q;
  assign TMO  = tmo_q;
endmodule

// File: tb/tb_bus_grant_sched.sv
// Bench for bus_grant_sched: three instances (TURN 1, 0, 3) share stimulus and are
// compared every cycle against an owner/gap-countdown model of the scheduling rules.
module tb_bus_grant_sched;
  localparam int unsigned N       = 4;
  localparam int unsigned MAXHOLD = 16;
  localparam int          NI      = 3;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] REQ;
  logic         LOCK;
  logic [N-1:0] g_a    [NI];
  logic [N-1:0] gnt_a  [NI];
  logic         busy_a [NI];
  logic         tmo_a  [NI];

  always #5 CLK = ~CLK;

  bus_grant_sched #(.N(N), .TURN(1), .MAXHOLD(MAXHOLD)) u_t1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK),
    ._G(g_a[0]), .GNT(gnt_a[0]), .BUSY(busy_a[0]), .TMO(tmo_a[0]));
  bus_grant_sched #(.N(N), .TURN(0), .MAXHOLD(MAXHOLD)) u_t0 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK),
    ._G(g_a[1]), .GNT(gnt_a[1]), .BUSY(busy_a[1]), .TMO(tmo_a[1]));
  bus_grant_sched #(.N(N), .TURN(3), .MAXHOLD(MAXHOLD)) u_t3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK),
    ._G(g_a[2]), .GNT(gnt_a[2]), .BUSY(busy_a[2]), .TMO(tmo_a[2]));

  // owner == -1 means nobody holds the bus; gap counts remaining dead cycles.
  typedef struct {
    int owner;
    int gap;
    int ptr;
    int held;
    bit tmo;
  } mdl_t;

  mdl_t m [NI];
  int   checks = 0;
  int   errors = 0;

  function automatic int turn_of(int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t pick(mdl_t mi, logic [N-1:0] req);
    mdl_t r = mi;
    for (int i = 0; i < int'(N); i++) begin
      int c = (mi.ptr + i) % int'(N);
      if (req[2'(c)]) begin
        r.owner = c;
        r.ptr   = (c + 1) % int'(N);
        r.held  = 0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic mdl_t step(mdl_t mi, logic [N-1:0] req, logic lock, logic rst, int turn);
    mdl_t r = mi;
    bit   rel;
    bit   forced;
    r.tmo = 1'b0;
    if (rst) begin
      r.owner = -1;
      r.gap   = 0;
      r.ptr   = 0;
      r.held  = 0;
      return r;
    end
    if (mi.owner >= 0) begin
      r.held = mi.held + 1;
      rel    = !req[2'(mi.owner)] && !lock;
      forced = 1'b0;
`ifdef BUS_GRANT_TIMEOUT_EN
      forced = !rel && !lock && r.held >= int'(MAXHOLD) && (req & ~(4'b1 << mi.owner)) != 4'b0;
`endif
      if (rel || forced) begin
        r.tmo   = forced;
        r.owner = -1;
        if (turn > 0) r.gap = turn;
        else r = pick(r, req);
      end
    end else if (mi.gap > 0) begin
      r.gap = mi.gap - 1;
      if (r.gap == 0) r = pick(r, req);
    end else begin
      r = pick(r, req);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_gnt(mdl_t mm);
    return (mm.owner >= 0) ? 4'(1 << mm.owner) : 4'b0;
  endfunction

  function automatic int idx_of(logic [N-1:0] g);
    for (int i = 0; i < int'(N); i++) if (g[2'(i)]) return i;
    return -1;
  endfunction

  // One clock: advance the models with the inputs sampled at the edge, then compare.
  task automatic cycle();
    @(posedge CLK);
    for (int k = 0; k < NI; k++) m[k] = step(m[k], REQ, LOCK, RST, turn_of(k));
    #1;
    for (int k = 0; k < NI; k++) begin
      logic [N-1:0] eg;
      logic [N-1:0] ng;
      eg = exp_gnt(m[k]);
      ng = ~eg;
      check($sformatf("G_t%0d", turn_of(k)), 32'(g_a[k]), 32'(ng));
      check($sformatf("GNT_t%0d", turn_of(k)), 32'(gnt_a[k]), 32'(eg));
      check($sformatf("BUSY_t%0d", turn_of(k)), 32'(busy_a[k]), 32'(m[k].owner >= 0));
      check($sformatf("TMO_t%0d", turn_of(k)), 32'(tmo_a[k]), 32'(m[k].tmo));
    end
  endtask

  initial begin
    int w;
    int waited;
    int own;
    bit tmo_seen;
    for (int k = 0; k < NI; k++) m[k] = '{owner: -1, gap: 0, ptr: 0, held: 0, tmo: 1'b0};
    RST  = 1'b1;
    REQ  = 4'b1111;
    LOCK = 1'b0;

    // Reset with every request pending, then first grant goes to requester 0.
    cycle();
    check("rst_G", 32'(g_a[0]), 32'hF);
    check("rst_GNT", 32'(gnt_a[0]), 32'h0);
    check("rst_BUSY", 32'(busy_a[0]), 32'h0);
    RST = 1'b0;
    cycle();
    check("first_grant", 32'(g_a[0]), 32'hE);

    // Round robin: each owner holds three cycles, drops for one edge, re-raises.
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      while (gnt_a[0] == 4'b0 && waited < 20) begin
        cycle();
        waited++;
      end
      if (gnt_a[0] == 4'b0) begin
        check("rr_wait", 32'(gnt_a[0] != 4'b0), 32'd1);
        break;
      end
      w = idx_of(gnt_a[0]);
      check("rr_order", 32'(w), 32'(n % 4));
      cycle();
      cycle();
      REQ[2'(w)] = 1'b0;
      cycle();
      REQ[2'(w)] = 1'b1;
    end

    // Owner 1 drops with requester 2 waiting: direct handover vs three dead cycles.
    RST = 1'b1; REQ = 4'b0000; cycle(); RST = 1'b0;
    REQ = 4'b0010; cycle();
    check("turn_own1", 32'(g_a[1]), 32'hD);
    REQ = 4'b0110; cycle();
    REQ = 4'b0100; cycle();
    check("t0_handover", 32'(g_a[1]), 32'hB);
    check("t3_gap1", 32'(g_a[2]), 32'hF);
    cycle();
    check("t3_gap2", 32'(g_a[2]), 32'hF);
    cycle();
    check("t3_gap3", 32'(g_a[2]), 32'hF);
    cycle();
    check("t3_grant", 32'(g_a[2]), 32'hB);

    // LOCK keeps the bus through five cycles of dropped request.
    RST = 1'b1; REQ = 4'b0000; cycle(); RST = 1'b0;
    REQ = 4'b0001; cycle();
    check("lock_own", 32'(g_a[0]), 32'hE);
    LOCK = 1'b1; REQ = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("lock_hold", 32'(g_a[0]), 32'hE);
    end
    LOCK = 1'b0;
    cycle();
    check("lock_release", 32'(g_a[0]), 32'hF);

    // Stuck requester 0 with requester 1 competing from its second owned cycle.
    RST = 1'b1; REQ = 4'b0000; cycle(); RST = 1'b0;
    REQ = 4'b0001; cycle();
    own = 1;
    tmo_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) REQ = 4'b0011;
      cycle();
      if (tmo_a[0]) tmo_seen = 1'b1;
      if (g_a[0] == 4'hE) own++;
      else break;
    end
`ifdef BUS_GRANT_TIMEOUT_EN
    check("hold_cycles", 32'(own), 32'd16);
    check("tmo_pulse", 32'(tmo_seen), 32'd1);
    cycle();
    check("tmo_next_owner", 32'(g_a[0]), 32'hD);
`else
    check("hold_cycles", 32'(own), 32'd41);
    check("tmo_pulse", 32'(tmo_seen), 32'd0);
`endif

    // Reset in the third cycle of an ownership, then regrant with latency one.
    RST = 1'b1; REQ = 4'b0000; LOCK = 1'b0; cycle(); RST = 1'b0;
    REQ = 4'b0100; cycle(); cycle(); cycle();
    RST = 1'b1; cycle();
    check("rst_mid_G", 32'(g_a[0]), 32'hF);
    check("rst_mid_BUSY", 32'(busy_a[0]), 32'h0);
    RST = 1'b0; cycle();
    check("regrant", 32'(g_a[0]), 32'hB);

    // Random traffic, alternating busy-toggling and long-hold phases.
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 250) % 2 == 1) ? 3 : 20;
      for (int r = 0; r < int'(N); r++)
        if ($urandom_range(0, 99) < p) REQ[2'(r)] = ~REQ[2'(r)];
      LOCK = ($urandom_range(0, 99) < 15);
      RST  = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
